// File: rtl/bus_arbiter_pkg.sv
// Shared constants and types for the 4-master round-robin bus arbiter.
// Active levels follow the bus convention: ENABLE_ = 0, DISABLE_ = 1.
package bus_arbiter_pkg;

  localparam int BUS_MASTER_CH = 4;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef logic [1:0] bus_owner_t;

  localparam bus_owner_t BUS_MASTER_0 = 2'd0;
  localparam bus_owner_t BUS_MASTER_1 = 2'd1;
  localparam bus_owner_t BUS_MASTER_2 = 2'd2;
  localparam bus_owner_t BUS_MASTER_3 = 2'd3;

  typedef enum logic {
    BUS_ARB_STATE_IDLE = 1'b0,
    BUS_ARB_STATE_OWN  = 1'b1
  } bus_arb_state_e;

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request in the order
// lastOwner+1, +2, +3, +4 (mod 4); lastOwner itself is considered last.
module bus_arb_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [BUS_MASTER_CH-1:0] reqVec,
  input  bus_owner_t               lastOwner,
  output bus_owner_t               pickIdx,
  output logic                     pickValid
);

  // Walk from the farthest position down so the nearest requester wins.
  always_comb begin
    pickIdx   = lastOwner;
    pickValid = 1'b0;
    for (int k = BUS_MASTER_CH; k >= 1; k--) begin
      if (reqVec[bus_owner_t'(lastOwner + bus_owner_t'(k))]) begin
        pickIdx   = bus_owner_t'(lastOwner + bus_owner_t'(k));
        pickValid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for 4 bus masters with active-low request/grant.
// Optional tenure limit enabled by defining BUS_ARB_TENURE_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int TENURE_W = 5
)
(
  input  logic       clk,
  input  logic       reset_,
  input  logic       m0Req_,
  input  logic       m1Req_,
  input  logic       m2Req_,
  input  logic       m3Req_,
  input  logic       busRdy_,
  output logic       m0Grnt_,
  output logic       m1Grnt_,
  output logic       m2Grnt_,
  output logic       m3Grnt_,
  output logic [1:0] busOwner,
  output logic       busIdle
);

  localparam logic [TENURE_W-1:0] TENURE_MAX = TENURE_W'(MAX_HOLD);

  bus_arb_state_e            state, stateNext;
  bus_owner_t                owner, ownerNext;
  bus_owner_t                lastOwner, lastOwnerNext;
  logic [TENURE_W-1:0]       tenure, tenureNext;
  logic [BUS_MASTER_CH-1:0]  grant_, grantNext_;
  logic [BUS_MASTER_CH-1:0]  reqVec, pickReq;
  bus_owner_t                pickBase, pickIdx;
  logic                      pickValid;

  assign reqVec = ~{m3Req_, m2Req_, m1Req_, m0Req_};

  // While owning, the owner is masked so a successor is always someone else.
  always_comb begin
    pickReq  = reqVec;
    pickBase = lastOwner;
    if (state == BUS_ARB_STATE_OWN) begin
      pickReq[owner] = 1'b0;
      pickBase       = owner;
    end
  end

  bus_arb_rr_pick u_pick (
    .reqVec    (pickReq),
    .lastOwner (pickBase),
    .pickIdx   (pickIdx),
    .pickValid (pickValid)
  );

  always_comb begin
    stateNext     = state;
    ownerNext     = owner;
    lastOwnerNext = lastOwner;
    tenureNext    = tenure;
    case (state)
      BUS_ARB_STATE_IDLE: begin
        tenureNext = '0;
        if (pickValid) begin
          stateNext = BUS_ARB_STATE_OWN;
          ownerNext = pickIdx;
        end
      end
      BUS_ARB_STATE_OWN: begin
        if (!reqVec[owner]) begin
          lastOwnerNext = owner;
          tenureNext    = '0;
          if (pickValid) ownerNext = pickIdx;
          else           stateNext = BUS_ARB_STATE_IDLE;
        end
`ifdef BUS_ARB_TENURE_EN
        else if (tenure == TENURE_MAX && pickValid && busRdy_ == ENABLE_) begin
          lastOwnerNext = owner;
          ownerNext     = pickIdx;
          tenureNext    = '0;
        end
`endif
        else if (tenure != TENURE_MAX) begin
          tenureNext = tenure + TENURE_W'(1);
        end
      end
      default: stateNext = BUS_ARB_STATE_IDLE;
    endcase
  end

`ifndef BUS_ARB_TENURE_EN
  logic unusedBusRdy;
  assign unusedBusRdy = busRdy_;
`endif

  // Grants are registered from the next state so a handover is a single edge.
  always_comb begin
    grantNext_ = {BUS_MASTER_CH{DISABLE_}};
    if (stateNext == BUS_ARB_STATE_OWN) grantNext_[ownerNext] = ENABLE_;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state     <= BUS_ARB_STATE_IDLE;
      owner     <= BUS_MASTER_0;
      lastOwner <= BUS_MASTER_3;
      tenure    <= '0;
      grant_    <= {BUS_MASTER_CH{DISABLE_}};
      busIdle   <= 1'b1;
    end else begin
      state     <= stateNext;
      owner     <= ownerNext;
      lastOwner <= lastOwnerNext;
      tenure    <= tenureNext;
      grant_    <= grantNext_;
      busIdle   <= (stateNext == BUS_ARB_STATE_IDLE);
    end
  end

  assign busOwner = owner;
  assign m0Grnt_  = grant_[BUS_MASTER_0];
  assign m1Grnt_  = grant_[BUS_MASTER_1];
  assign m2Grnt_  = grant_[BUS_MASTER_2];
  assign m3Grnt_  = grant_[BUS_MASTER_3];

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, directed corner cases
// and random traffic against a rule-level model (honours BUS_ARB_TENURE_EN).
module tb_bus_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int TENURE_W = 5;

  logic       clk = 1'b0;
  logic       reset_;
  logic       m0Req_, m1Req_, m2Req_, m3Req_;
  logic       busRdy_;
  logic       m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_;
  logic [1:0] busOwner;
  logic       busIdle;

  int total = 0;
  int bad   = 0;

  int mOwner, mLast, mTenure;
  bit mIdle;

  typedef struct {
    logic [3:0] reqN;
    logic       rdyN;
    logic [3:0] expGrnt;
    logic [1:0] expOwner;
    logic       expIdle;
  } vec_t;

  vec_t vecs[12];

  bus_arbiter #(.MAX_HOLD(MAX_HOLD), .TENURE_W(TENURE_W)) dut (
    .clk      (clk),
    .reset_   (reset_),
    .m0Req_   (m0Req_),
    .m1Req_   (m1Req_),
    .m2Req_   (m2Req_),
    .m3Req_   (m3Req_),
    .busRdy_  (busRdy_),
    .m0Grnt_  (m0Grnt_),
    .m1Grnt_  (m1Grnt_),
    .m2Grnt_  (m2Grnt_),
    .m3Grnt_  (m3Grnt_),
    .busOwner (busOwner),
    .busIdle  (busIdle)
  );

  always #5 clk = ~clk;

  function automatic int rrPick(input logic [3:0] req, input int base);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (base + k) % 4;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mOwner  = 0;
    mLast   = 3;
    mTenure = 0;
    mIdle   = 1'b1;
  endtask

  // Rule-level reference: one call per rising edge using the held inputs.
  task automatic modelStep(input logic [3:0] reqN, input logic rdyN);
    logic [3:0] req;
    logic [3:0] others;
    int p;
    req = ~reqN;
    if (mIdle) begin
      p = rrPick(req, mLast);
      mTenure = 0;
      if (p >= 0) begin
        mIdle  = 1'b0;
        mOwner = p;
      end
    end else if (!req[mOwner]) begin
      p = rrPick(req, mOwner);
      mLast   = mOwner;
      mTenure = 0;
      if (p >= 0) mOwner = p;
      else        mIdle  = 1'b1;
    end else begin
      others = req;
      others[mOwner] = 1'b0;
      p = rrPick(others, mOwner);
`ifdef BUS_ARB_TENURE_EN
      if (mTenure == MAX_HOLD && p >= 0 && rdyN == 1'b0) begin
        mLast   = mOwner;
        mOwner  = p;
        mTenure = 0;
      end else
`endif
      mTenure = (mTenure < MAX_HOLD) ? mTenure + 1 : MAX_HOLD;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expGrnt,
                             input logic [1:0] expOwner, input logic expIdle);
    logic [3:0] g;
    g = {m3Grnt_, m2Grnt_, m1Grnt_, m0Grnt_};
    total++;
    if (g !== expGrnt) begin
      bad++;
      $display("[TB] FAIL %s grants: got %b want %b", tag, g, expGrnt);
    end
    total++;
    if (busOwner !== expOwner) begin
      bad++;
      $display("[TB] FAIL %s busOwner: got %0d want %0d", tag, busOwner, expOwner);
    end
    total++;
    if (busIdle !== expIdle) begin
      bad++;
      $display("[TB] FAIL %s busIdle: got %b want %b", tag, busIdle, expIdle);
    end
  endtask

  task automatic modelCheck(input string tag);
    logic [3:0] g;
    g = 4'hF;
    if (!mIdle) g[mOwner] = 1'b0;
    checkOutput(tag, g, 2'(mOwner), mIdle);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input logic [3:0] reqN, input logic rdyN);
    {m3Req_, m2Req_, m1Req_, m0Req_} = reqN;
    busRdy_ = rdyN;
    @(posedge clk);
    modelStep(reqN, rdyN);
    @(negedge clk);
  endtask

  task automatic applyReset();
    {m3Req_, m2Req_, m1Req_, m0Req_} = 4'hF;
    busRdy_ = 1'b1;
    reset_  = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", 4'hF, 2'd0, 1'b1);
    reset_ = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{4'b1011, 1'b1, 4'b1011, 2'd2, 1'b0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b1111, 2'd2, 1'b1};
    vecs[2]  = '{4'b0000, 1'b1, 4'b0111, 2'd3, 1'b0};
    vecs[3]  = '{4'b1000, 1'b1, 4'b1110, 2'd0, 1'b0};
    vecs[4]  = '{4'b0001, 1'b1, 4'b1101, 2'd1, 1'b0};
    vecs[5]  = '{4'b0010, 1'b1, 4'b1011, 2'd2, 1'b0};
    vecs[6]  = '{4'b0100, 1'b1, 4'b0111, 2'd3, 1'b0};
    vecs[7]  = '{4'b1000, 1'b1, 4'b1110, 2'd0, 1'b0};
    vecs[8]  = '{4'b0000, 1'b1, 4'b1110, 2'd0, 1'b0};
    vecs[9]  = '{4'b1111, 1'b1, 4'b1111, 2'd0, 1'b1};
    vecs[10] = '{4'b1110, 1'b1, 4'b1110, 2'd0, 1'b0};
    vecs[11] = '{4'b1110, 1'b1, 4'b1110, 2'd0, 1'b0};

    reset_ = 1'b0;
    {m3Req_, m2Req_, m1Req_, m0Req_} = 4'hF;
    busRdy_ = 1'b1;
    @(negedge clk);
    applyReset();

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].reqN, vecs[i].rdyN);
      checkOutput($sformatf("vec%0d", i), vecs[i].expGrnt, vecs[i].expOwner, vecs[i].expIdle);
    end

    // All four request from idle; each release walks the rotation 0,1,2,3,0.
    applyReset();
    begin
      logic [3:0] pats[5];
      logic [1:0] order[5];
      logic [3:0] g;
      pats  = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      for (int i = 0; i < 5; i++) begin
        applyStimulus(pats[i], 1'b1);
        g = 4'hF;
        g[order[i]] = 1'b0;
        checkOutput($sformatf("rot%0d", i), g, order[i], 1'b0);
      end
    end

    // Owner 1 releases while master 3 requests in the same cycle.
    applyReset();
    applyStimulus(4'b1101, 1'b1);
    checkOutput("own1", 4'b1101, 2'd1, 1'b0);
    applyStimulus(4'b0111, 1'b1);
    checkOutput("handover13", 4'b0111, 2'd3, 1'b0);

    // Owner 0 releases to idle, then re-requests.
    applyReset();
    applyStimulus(4'b1110, 1'b1);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("release0", 4'b1111, 2'd0, 1'b1);
    applyStimulus(4'b1110, 1'b1);
    checkOutput("regrant0", 4'b1110, 2'd0, 1'b0);

    // Asynchronous reset in the middle of ownership by master 2.
    applyReset();
    applyStimulus(4'b1011, 1'b1);
    checkOutput("own2", 4'b1011, 2'd2, 1'b0);
    #2 reset_ = 1'b0;
    modelReset();
    #1 checkOutput("asyncReset", 4'hF, 2'd0, 1'b1);
    @(negedge clk);
    {m3Req_, m2Req_, m1Req_, m0Req_} = 4'hF;
    reset_ = 1'b1;

    // Owner 0 holds while master 1 waits; tenure limit applies only with the macro.
    applyReset();
    applyStimulus(4'b1110, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1100, 1'b1);
      checkOutput($sformatf("hold%0d", i), 4'b1110, 2'd0, 1'b0);
    end
`ifdef BUS_ARB_TENURE_EN
    applyStimulus(4'b1100, 1'b0);
    checkOutput("revoke", 4'b1101, 2'd1, 1'b0);
`else
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b1100, 1'b0);
      checkOutput($sformatf("keep%0d", i), 4'b1110, 2'd0, 1'b0);
    end
`endif

    // Random traffic against the reference model.
    applyReset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 99) < 40);
      applyStimulus(r, ($urandom_range(0, 99) < 30) ? 1'b0 : 1'b1);
      modelCheck($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Master-side counterpart of the slave chip-select decode: selects which of 4 bus masters drives the shared address/control/write-data bus.
- Round-robin, active-low request/grant per master; grant changes only at transaction boundaries.
- Exports the current owner index, which drives the master-side bus multiplexer. The slave-select decode then runs on that owner's address.

Parameters:
- MAX_HOLD, 16, max cycles an owner keeps the bus while others wait (used only with the optional feature); legal range 2..31.
- TENURE_W, 5, tenure counter width; must satisfy 2^TENURE_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- reset_  input  1  asynchronous, active-low reset.
- m0Req_  input  1  master 0 bus request, active-low.
- m1Req_  input  1  master 1 bus request, active-low.
- m2Req_  input  1  master 2 bus request, active-low.
- m3Req_  input  1  master 3 bus request, active-low.
- busRdy_  input  1  selected slave ready (active-low), marks end of the current transfer.
- m0Grnt_  output  1  master 0 grant, active-low, registered.
- m1Grnt_  output  1  master 1 grant, active-low, registered.
- m2Grnt_  output  1  master 2 grant, active-low, registered.
- m3Grnt_  output  1  master 3 grant, active-low, registered.
- busOwner  output  2  index of granted master; valid when busIdle is deasserted.
- busIdle  output  1  active-high; no master granted.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_.
- Reset values:
  - all mNGrnt_ = `DISABLE_ (1)
  - busOwner = 0, busIdle = 1
  - state = IDLE
  - lastOwner = 3, so the first pick is master 0
  - tenure = 0
- Deassertion of reset_ takes effect at the next clk edge.
- State IDLE:
  - All grants disabled.
  - If any req_ is asserted, go to OWN.
  - Owner = first asserting master in rotated order lastOwner+1, +2, +3, +4 (mod 4).
  - Latency: grant asserted 1 cycle after the req_ sampled.
- State OWN:
  - Exactly one grant asserted, matching busOwner; busIdle = 0.
  - If the owner deasserts req_ and no other req_ is asserted: go to IDLE next cycle; lastOwner = owner.
  - If the owner deasserts req_ and another req_ is asserted: switch directly to the next rotated requester. No idle cycle, no grant overlap. The old grant deasserts and the new grant asserts on the same edge.
  - If the owner keeps req_ asserted: grant held (subject to the optional feature).
- Rotation always excludes the current owner when choosing a successor after release. The owner is considered only as position 4 of the order.
- Simultaneous events:
  - Owner release and a new request in the same cycle: the new requester is granted next cycle.
  - Multiple new requesters: rotation order decides.
- Reset mid-ownership: all grants drop asynchronously. No pending state survives reset.
- Tenure counter:
  - Cleared on every grant change and in IDLE.
  - Increments each OWN cycle and saturates at MAX_HOLD.
- Ports not otherwise covered by these rules hold their values.

Optional Feature:
- Macro: BUS_ARB_TENURE_EN.
- Defined: in OWN, if tenure == MAX_HOLD, another req_ is asserted, and busRdy_ == `ENABLE_ (0), the grant is revoked on that edge. The next rotated requester is granted at the same edge; lastOwner = old owner. The revoked master must re-request to regain the bus. If busRdy_ is not asserted, the grant is held until it is.
- Undefined: tenure logic absent; the owner keeps the bus until it drops req_. busRdy_ is unused.

Decomposition:
- bus.vh gains:
  - BUS_MASTER_CH (4)
  - BUS_OWNER_BUS ([1:0])
  - BUS_MASTER_0..BUS_MASTER_3 index constants
  - BUS_ARB_STATE_BUS, BUS_ARB_STATE_IDLE, BUS_ARB_STATE_OWN
- Active levels use `ENABLE_/`DISABLE_ from stddef.vh.
- Sub-module bus_arb_rr_pick: combinational. Inputs are the 4-bit request vector and lastOwner. Outputs are the picked index and a valid flag.

Test Plan:
- Reset then m2Req_=0 alone -> m2Grnt_=0 at cycle+1, busOwner=2, busIdle=0. Other grants stay 1.
- All four req_=0 from IDLE after reset -> grant order on successive releases is 0,1,2,3,0. Each release is done by deasserting the owner's req_ for 1 cycle. No cycle has two grants asserted.
- Owner 1 releases while m3Req_=0 in the same cycle -> m1Grnt_=1 and m3Grnt_=0 on the same edge; busIdle never 1.
- Owner 0 releases with no requesters -> busIdle=1 next cycle. m0Req_ reasserted -> m0Grnt_=0 one cycle later.
- reset_ pulsed low mid-OWN (owner 2) -> all grants 1 immediately, before the next clk edge. busOwner=0 and busIdle=1 after reset.
- With BUS_ARB_TENURE_EN, MAX_HOLD=4:
  - Owner 0 holds; m1Req_=0; busRdy_=1 -> grant held.
  - busRdy_=0 after tenure 4 -> m1Grnt_=0 on that edge.
  - Without the macro -> owner 0 retains the bus indefinitely.
